ifetch_unit: RTL

// Instruction fetch stage directly upstream of the memory unit's instruction port. Holds the PC,

---
 rtl/ifetch_unit_pkg.sv | 32 +++
 rtl/ifetch_unit_if.sv | 30 +++
 rtl/ifetch_unit_inst_queue.sv | 72 +++++++
 rtl/ifetch_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: queue entry layout,
// fetch FSM states, RISC-V opcodes used by the static predictor and immediate decoders.
package ifetch_unit_pkg;

  localparam int IQ_DEPTH_BIT_DEF = 3;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction port towards the memory unit and the queue head towards the decoder.
// master = fetch unit, slave = memory unit / decoder side.
interface ifetch_unit_if;

  logic [31:0] mem_pc;
  logic        mem_inst_req;
  logic        mem_inst_ready;
  logic [31:0] mem_inst;

  logic        dec_pop;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;

  modport master (
    output mem_pc, mem_inst_req,
    input  mem_inst_ready, mem_inst,
    input  dec_pop,
    output dec_valid, dec_inst, dec_pc, dec_pred_taken
  );

  modport slave (
    input  mem_pc, mem_inst_req,
    output mem_inst_ready, mem_inst,
    output dec_pop,
    input  dec_valid, dec_inst, dec_pc, dec_pred_taken
  );

endinterface

// File: rtl/ifetch_unit_inst_queue.sv
// In-order circular instruction queue: push at tail, pop at head, clear on flush.
// A full queue refuses a push even when a pop happens in the same cycle.
module ifetch_unit_inst_queue
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH_BIT = IQ_DEPTH_BIT_DEF
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      en_i,
  input  logic      clear_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  iq_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output iq_entry_t head_o
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [DEPTH_BIT-1:0] head_q, head_d;
  logic [DEPTH_BIT-1:0] tail_q, tail_d;
  logic [DEPTH_BIT:0]   count_q, count_d;
  iq_entry_t            mem_q [DEPTH];
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == (DEPTH_BIT+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[head_q];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only visible once count_q covers it.
  always_ff @(posedge clk_in) begin
    if (en_i && !clear_i && push_ok) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, RUN/WAIT fetch FSM, flush redirect and instruction queue.
// Define IFU_PREDICT_EN to enable static JAL/backward-branch prediction and stop-on-JALR.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int          IQ_DEPTH_BIT = IQ_DEPTH_BIT_DEF,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  input  logic [31:0]   flush_pc,
  ifetch_unit_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  next_pc;
  logic         pred_taken;
  logic         stop_fetch;
  logic         fire;
  logic         iq_full, iq_empty;
  iq_entry_t    push_entry, iq_head;

  assign bus.mem_pc       = pc_q;
  assign bus.mem_inst_req = !rst_in && (state_q == ST_RUN) && !iq_full && !flush_in;
  assign fire             = bus.mem_inst_req && bus.mem_inst_ready;

  always_comb begin
    next_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
    stop_fetch = 1'b0;
`ifdef IFU_PREDICT_EN
    case (bus.mem_inst[6:0])
      OPC_JAL: begin
        next_pc    = pc_q + imm_j(bus.mem_inst);
        pred_taken = 1'b1;
      end
      OPC_BRANCH: begin
        // Backward branches (negative offset) are predicted taken.
        if (bus.mem_inst[31]) begin
          next_pc    = pc_q + imm_b(bus.mem_inst);
          pred_taken = 1'b1;
        end
      end
      OPC_JALR: stop_fetch = 1'b1;
      default:  stop_fetch = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc_q    <= flush_pc;
        state_q <= ST_RUN;
      end else if (fire) begin
        pc_q <= next_pc;
        if (stop_fetch) state_q <= ST_WAIT;
      end
    end
  end

  assign push_entry = '{pc: pc_q, inst: bus.mem_inst, pred: pred_taken};

  ifetch_unit_inst_queue #(
    .DEPTH_BIT (IQ_DEPTH_BIT)
  ) u_iq (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_i    (rdy_in),
    .clear_i (flush_in),
    .push_i  (fire),
    .pop_i   (bus.dec_pop),
    .data_i  (push_entry),
    .full_o  (iq_full),
    .empty_o (iq_empty),
    .head_o  (iq_head)
  );

  assign bus.dec_valid      = !iq_empty;
  assign bus.dec_pc         = iq_head.pc;
  assign bus.dec_inst       = iq_head.inst;
  assign bus.dec_pred_taken = iq_head.pred;

endmodule
